// File: rtl/store_fwd_unit.sv
// Store-data forwarding mux with retired-writeback history and one-bubble load-use stall.
// Optional event counters are enabled by defining STORE_FWD_STATS_EN.
module store_fwd_unit #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              in_clk,
   input  logic              in_rst_n,
   input  logic              in_req,
   input  logic [ADDR_W-1:0] in_rs_addr,
   input  logic [DATA_W-1:0] in_B,
   input  logic [DATA_W-1:0] in_R,
   input  logic [ADDR_W-1:0] in_R_addr,
   input  logic              in_R_we,
   input  logic              in_R_is_load,
   input  logic [DATA_W-1:0] in_WB,
   input  logic [ADDR_W-1:0] in_WB_addr,
   input  logic              in_WB_we,
   input  logic              in_flush,
   output logic [DATA_W-1:0] out_B,
   output logic [2:0]        out_sel,
   output logic              out_stall
`ifdef STORE_FWD_STATS_EN
   ,
   output logic [31:0]       out_hit_cnt,
   output logic [31:0]       out_stall_cnt
`endif
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [2:0]  SEL_B = 3'b000;
   localparam logic [2:0]  SEL_R = 3'b001;
   localparam logic [2:0]  SEL_WB = 3'b010;
   localparam logic [2:0]  SEL_HIST = 3'b011;

   typedef enum logic {ST_RUN, ST_LOAD_WAIT} state_t;

   state_t            r_state;
   logic [DEPTH-1:0]  r_hist_vld;
   logic [ADDR_W-1:0] r_hist_addr [DEPTH];
   logic [DATA_W-1:0] r_hist_data [DEPTH];
   logic [PTR_W-1:0]  r_wrptr;

   logic              w_lookup;
   logic              w_r_match;
   logic              w_r_hit;
   logic              w_load_haz;
   logic              w_wb_hit;
   logic              w_push;
   logic              w_hist_hit;
   logic [DATA_W-1:0] w_hist_data;
   logic [PTR_W-1:0]  w_idx;

   // Register 0 never forwards, so a zero source disables every match.
   assign w_lookup   = in_req & (in_rs_addr != '0);
   assign w_r_match  = w_lookup & in_R_we & (in_R_addr == in_rs_addr);
   assign w_r_hit    = w_r_match & ~in_R_is_load;
   assign w_load_haz = w_r_match & in_R_is_load;
   assign w_wb_hit   = w_lookup & in_WB_we & (in_WB_addr == in_rs_addr);
   assign w_push     = in_WB_we & (in_WB_addr != '0);

   // Walk oldest to newest so the youngest matching entry wins.
   always_comb begin
      w_hist_hit  = 1'b0;
      w_hist_data = '0;
      w_idx       = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         w_idx = r_wrptr - PTR_W'(i) - PTR_W'(1);
         if (w_lookup && r_hist_vld[w_idx] && (r_hist_addr[w_idx] == in_rs_addr)) begin
            w_hist_hit  = 1'b1;
            w_hist_data = r_hist_data[w_idx];
         end
      end
   end

   always_comb begin
      out_sel = SEL_B;
      out_B   = in_B;
      if (w_r_hit) begin
         out_sel = SEL_R;
         out_B   = in_R;
      end else if (w_wb_hit) begin
         out_sel = SEL_WB;
         out_B   = in_WB;
      end else if (w_hist_hit) begin
         out_sel = SEL_HIST;
         out_B   = w_hist_data;
      end
   end

   // Gated by reset so an asserted reset drops the stall without waiting for a clock.
   assign out_stall = in_rst_n & (r_state == ST_RUN) & w_load_haz;

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_state <= ST_RUN;
      end else begin
         case (r_state)
            ST_RUN:       if (w_load_haz) r_state <= ST_LOAD_WAIT;
            ST_LOAD_WAIT: r_state <= ST_RUN;
            default:      r_state <= ST_RUN;
         endcase
      end
   end

   // Flush clears first; a same-cycle push lands valid on top of the clear.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_hist_vld <= '0;
         r_wrptr    <= '0;
      end else begin
         if (in_flush) r_hist_vld <= '0;
         if (w_push) begin
            r_hist_vld[r_wrptr] <= 1'b1;
            r_wrptr             <= r_wrptr + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge in_clk) begin
      if (w_push) begin
         r_hist_addr[r_wrptr] <= in_WB_addr;
         r_hist_data[r_wrptr] <= in_WB;
      end
   end

`ifdef STORE_FWD_STATS_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_stall_cnt;

   // Saturating event counters.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_hit_cnt   <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (in_req && (out_sel != SEL_B) && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + 32'd1;
         if (out_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign out_hit_cnt   = r_hit_cnt;
   assign out_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/store_fwd_unit.md
Name: store_fwd_unit

Overview:
- Parametrised successor to the 2-bit store-data forwarding mux.
- Sits between register-file read and the data-memory write port in the 5-stage pipeline.
- Selects the store operand from the youngest producer: EX/MEM result, MEM/WB writeback, or a DEPTH-entry history of retired writebacks. Otherwise it uses the register-file value.
- Owns the load-use stall for store data: exactly one bubble, tracked by a small FSM.

Parameters:
DATA_W, 32, operand/result width
ADDR_W, 5, register number width
DEPTH, 4, retired-writeback history entries (power of two, 2..16)

Ports:
in_clk  input  1  clock, rising edge
in_rst_n  input  1  asynchronous active-low reset
in_req  input  1  store operand requested this cycle
in_rs_addr  input  ADDR_W  store data source register
in_B  input  DATA_W  register-file read value
in_R  input  DATA_W  EX/MEM result
in_R_addr  input  ADDR_W  EX/MEM destination
in_R_we  input  1  EX/MEM writes a register
in_R_is_load  input  1  EX/MEM instruction is a load (in_R not valid data)
in_WB  input  DATA_W  MEM/WB writeback value
in_WB_addr  input  ADDR_W  MEM/WB destination
in_WB_we  input  1  MEM/WB writes a register
in_flush  input  1  pipeline flush, clears history
out_B  output  DATA_W  forwarded store data (combinational)
out_sel  output  3  000 B, 001 R, 010 WB, 011 history, others unused
out_stall  output  1  hold decode/EX one cycle

Behaviour:
- Clock and reset: one clock in_clk; reset in_rst_n is asynchronous, active-low.
- Reset state: all history valid bits clear, write pointer 0, FSM in RUN.
- Reset outputs: out_stall=0. out_sel and out_B follow the combinational rules with an empty history, so with in_req=0 they read 000 / in_B.
- Register 0 is never forwarded. Any match with addr 0 is ignored, and a WB write to addr 0 is not pushed.
- Match priority, youngest first:
  - R: in_R_we & in_R_addr==in_rs_addr & !in_R_is_load
  - WB: in_WB_we & addr match
  - history: newest to oldest, searching backward from wrptr-1 modulo DEPTH
  - default: in_B
- in_req=0: out_sel=000, out_B=in_B, out_stall=0.
- History push: on the clock edge with in_WB_we & in_WB_addr!=0:
  - entry[wrptr] <= {addr, in_WB}, valid set
  - wrptr <= wrptr+1, wrapping DEPTH-1 -> 0
  - When the buffer is full, the oldest entry is overwritten.
  - Duplicate addresses may coexist; age order resolves them.
- Flush: in_flush clears every valid bit at the edge. If a push occurs the same cycle, the pushed entry is written valid after the clear. wrptr is unchanged.
- FSM states:
  - RUN: if in_req & in_R_we & in_R_is_load & in_R_addr==in_rs_addr & addr!=0, then out_stall=1 (combinational) and go to LOAD_WAIT. While stalled, out_sel/out_B show the next-priority source; the consumer must ignore them.
  - LOAD_WAIT: out_stall=0 unconditionally (the load is now in WB and forwarded from in_WB); always return to RUN next cycle.
  - Consequence: at most one bubble per hazard, and never two consecutive stall cycles.
- in_flush in LOAD_WAIT: return to RUN.
- Reset asserted mid-stall: FSM goes immediately to RUN and out_stall drops asynchronously.
- Latency: forwarding is zero-cycle (combinational). A history entry becomes visible the cycle after its push.

Optional Feature:
- Macro: STORE_FWD_STATS_EN.
- When defined, add outputs:
  - out_hit_cnt (32 bits): counts cycles with in_req=1 and out_sel!=000.
  - out_stall_cnt (32 bits): counts cycles with out_stall=1.
  - Both reset to 0 and saturate at all-ones.
- When undefined, neither the ports nor the counters exist, and all other behaviour is identical.

Test Plan:
- Reset, in_req=1, rs=5, in_B=0x11 -> out_sel=000, out_B=0x11, out_stall=0.
- rs=3; R writes r3=0xAA; WB writes r3=0xBB -> out_sel=001, out_B=0xAA. Drop R_we -> out_sel=010, out_B=0xBB.
- Push WB r7=0x1, r7=0x2, then r9 (DEPTH=4); request rs=7 with no live R/WB -> out_sel=011, out_B=0x2. Push 4 more non-r7 writes -> r7 evicted, out_sel=000.
- Load in EX/MEM to r4, store rs=4 -> out_stall=1 for one cycle. Next cycle, in_WB=0xCC for r4 -> out_stall=0, out_sel=010, out_B=0xCC.
- rs=0 with R/WB/history all targeting r0 -> out_sel=000, no stall, no push.
- Fill history, assert in_flush with a simultaneous push r2=0x5 -> only r2 hits. Assert in_rst_n=0 during LOAD_WAIT -> out_stall=0 at once, FSM in RUN.
